// File: rtl/keypad_pkg.sv
// Shared types, key map and small helpers for the hex keypad entry block.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } deb_state_t;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_kind_t;

  // Key code for each switch, indexed {row, col}.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Number of pressed switches in one row sample (active-high input).
  function automatic logic [2:0] count_pressed(input logic [3:0] pressed);
    logic [2:0] n;
    n = '0;
    for (int c = 0; c < 4; c++) begin
      n = n + {2'b00, pressed[c]};
    end
    return n;
  endfunction

  // Highest-numbered pressed column; later columns overwrite earlier ones.
  function automatic logic [1:0] last_col(input logic [3:0] pressed);
    logic [1:0] col;
    col = '0;
    for (int c = 0; c < 4; c++) begin
      if (pressed[c]) col = 2'(c);
    end
    return col;
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Row scanner: column synchroniser, row rotation timer and per-frame
// accumulation of pressed switches. Reports a frame result on the row-3
// sample cycle.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_COUNT = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic        frame_done,
  output frame_kind_t frame_kind,
  output logic [3:0]  frame_code
);

  localparam int CW = (SCAN_COUNT > 0) ? $clog2(SCAN_COUNT + 1) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SCAN_COUNT);

  logic [3:0]    col_meta;
  logic [3:0]    col_sync;
  logic [3:0]    row_state;
  logic [CW-1:0] remain;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;

  logic          tc;
  logic [1:0]    row_idx;
  logic [3:0]    pressed;
  logic [2:0]    row_hits;
  logic [2:0]    total;
  logic [1:0]    next_cnt;
  logic [3:0]    next_code;

  // Remaining cycles in the current row; the row is sampled when it hits zero.
  assign tc         = (remain == '0);
  assign pressed    = ~col_sync;
  assign row_hits   = count_pressed(pressed);
  assign total      = {1'b0, acc_cnt} + row_hits;
  assign next_cnt   = (total > 3'd1) ? 2'd2 : total[1:0];
  assign next_code  = (row_hits != 3'd0) ? KEYMAP[{row_idx, last_col(pressed)}] : acc_code;
  assign frame_done = tc & row_state[3];
  assign frame_code = next_code;
  assign row        = ~row_state;

  // One-hot row drive to row number.
  always_comb begin
    row_idx = '0;
    for (int r = 0; r < 4; r++) begin
      if (row_state[r]) row_idx = 2'(r);
    end
  end

  // Frame result including the row-3 sample taken this cycle.
  always_comb begin
    case (next_cnt)
      2'd0:    frame_kind = FR_NONE;
      2'd1:    frame_kind = FR_SINGLE;
      default: frame_kind = FR_MULTI;
    endcase
  end

  // Two-flop synchroniser for the asynchronous column lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
    end
  end

  // Row timer and rotation of the active-low row drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain    <= RELOAD;
      row_state <= 4'b0001;
    end else if (tc) begin
      remain    <= RELOAD;
      row_state <= {row_state[2:0], row_state[3]};
    end else begin
      remain    <= remain - CW'(1);
    end
  end

  // Per-frame switch count (saturating at 2) and last code seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt  <= '0;
      acc_code <= '0;
    end else if (tc) begin
      if (row_state[3]) begin
        acc_cnt  <= '0;
        acc_code <= '0;
      end else begin
        acc_cnt  <= next_cnt;
        acc_code <= next_code;
      end
    end
  end

endmodule

// File: rtl/keypad_hex_entry.sv
// Hex keypad entry: scans a 4x4 matrix, debounces per frame, pulses once per
// accepted press and shifts each accepted digit into a 32-bit value.
//
// state        | meaning
// -------------+----------------------------------------------------------
// IDLE         | no key held, waiting for a single-key frame
// PRESS_WAIT   | counting consecutive frames showing the same single key
// HELD         | press reported, waiting for an empty frame
// RELEASE_WAIT | counting consecutive empty frames before re-arming
module keypad_hex_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_COUNT     = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [3:0]  col_in,
  input  logic        clear_in,
  output logic [3:0]  row_out,
  output logic        key_valid_out,
  output logic [3:0]  key_code_out,
  output logic [31:0] val_out
);

  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_SCANS - 1);

  logic        frame_done;
  frame_kind_t frame_kind;
  logic [3:0]  frame_code;

  deb_state_t    state, state_nxt;
  logic [3:0]    cand, cand_nxt;
  logic [DW-1:0] cnt, cnt_nxt;
  logic          fire;

  keypad_scanner #(
    .SCAN_COUNT (SCAN_COUNT)
  ) u_scanner (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .col        (col_in),
    .row        (row_out),
    .frame_done (frame_done),
    .frame_kind (frame_kind),
    .frame_code (frame_code)
  );

  // Debounce state, candidate key and the one-cycle report pulse.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      cand          <= '0;
      cnt           <= '0;
      key_valid_out <= 1'b0;
      key_code_out  <= '0;
    end else begin
      state         <= state_nxt;
      cand          <= cand_nxt;
      cnt           <= cnt_nxt;
      key_valid_out <= fire;
      if (fire) key_code_out <= cand;
    end
  end

  // Next-state logic; only a frame result can move the FSM.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    fire      = 1'b0;
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (frame_kind == FR_SINGLE) begin
            state_nxt = PRESS_WAIT;
            cand_nxt  = frame_code;
            cnt_nxt   = DW'(1);
          end
        end
        PRESS_WAIT: begin
          if (frame_kind == FR_SINGLE && frame_code == cand) begin
            if (cnt == DEB_LAST) begin
              state_nxt = HELD;
              cnt_nxt   = '0;
              fire      = 1'b1;
            end else begin
              cnt_nxt = cnt + DW'(1);
            end
          end else if (frame_kind == FR_SINGLE) begin
            cand_nxt = frame_code;
            cnt_nxt  = DW'(1);
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        HELD: begin
          if (frame_kind == FR_NONE) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = DW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (frame_kind == FR_NONE) begin
            if (cnt == DEB_LAST) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + DW'(1);
            end
          end else begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Digit accumulator; a clear in the report cycle drops that digit.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      val_out <= '0;
    end else if (clear_in) begin
      val_out <= '0;
    end else if (key_valid_out) begin
      val_out <= {val_out[27:0], key_code_out};
    end
  end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Bench for keypad_hex_entry: a physical keypad model drives the columns,
// a frame-level reference model predicts reports, and a monitor checks them.
module tb_keypad_hex_entry;

  localparam int SC    = 3;
  localparam int DS    = 2;
  localparam int FRAME = 4 * (SC + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col_in;
  logic        clear_in = 1'b0;
  logic [3:0]  row_out;
  logic        key_valid_out;
  logic [3:0]  key_code_out;
  logic [31:0] val_out;

  logic [15:0] key_mat = '0;
  int          checks = 0;
  int          errors = 0;
  int          edge_cnt;

  typedef struct {
    logic [3:0]  code;
    int          edge_no;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  int          single_run;
  int          none_run;
  logic [3:0]  run_code;
  bit          armed;
  logic [31:0] mval;

  always #5 clk = ~clk;

  keypad_hex_entry #(
    .SCAN_COUNT     (SC),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .col_in        (col_in),
    .clear_in      (clear_in),
    .row_out       (row_out),
    .key_valid_out (key_valid_out),
    .key_code_out  (key_code_out),
    .val_out       (val_out)
  );

  // Matrix keypad: a held switch pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_mat[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [3:0] key_code_of(input int idx);
    case (idx)
      0: return 4'h1;  1: return 4'h2;  2: return 4'h3;  3: return 4'hA;
      4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'hB;
      8: return 4'h7;  9: return 4'h8; 10: return 4'h9; 11: return 4'hC;
     12: return 4'hE; 13: return 4'h0; 14: return 4'hF; default: return 4'hD;
    endcase
  endfunction

  function automatic logic [15:0] k(input int r, input int c);
    return 16'(1) << (r * 4 + c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    single_run = 0;
    none_run   = 0;
    run_code   = '0;
    armed      = 1'b1;
    mval       = '0;
  endtask

  // A press is accepted after DS identical single-key frames while armed;
  // re-arming needs DS consecutive empty frames.
  task automatic model_step(input logic [15:0] keys, output bit acc, output logic [3:0] code);
    int n;
    int idx;
    n   = $countones(keys);
    idx = 0;
    acc = 1'b0;
    for (int i = 0; i < 16; i++) if (keys[i]) idx = i;
    code = key_code_of(idx);
    if (n == 1) begin
      if (single_run > 0 && code == run_code) single_run++;
      else begin
        single_run = 1;
        run_code   = code;
      end
      none_run = 0;
    end else if (n == 0) begin
      single_run = 0;
      none_run++;
    end else begin
      single_run = 0;
      none_run   = 0;
    end
    if (armed && single_run == DS) begin
      acc   = 1'b1;
      armed = 1'b0;
    end else if (!armed && none_run == DS) begin
      armed = 1'b1;
    end
  endtask

  task automatic wait_frame_end();
    do begin
      @(posedge clk);
      #1;
    end while (edge_cnt % FRAME != 0);
  endtask

  task automatic frame(input logic [15:0] keys, input bit clr);
    bit         acc;
    logic [3:0] code;
    key_mat = keys;
    wait_frame_end();
    model_step(keys, acc, code);
    if (acc) begin
      mval = clr ? 32'h0 : {mval[27:0], code};
      sb_q.push_back('{code: code, edge_no: edge_cnt, val: mval});
    end else if (clr) begin
      mval = '0;
    end
    if (clr) begin
      clear_in = 1'b1;
      @(posedge clk);
      #1;
      clear_in = 1'b0;
    end
  endtask

  task automatic frames(input logic [15:0] keys, input int n);
    for (int i = 0; i < n; i++) frame(keys, 1'b0);
  endtask

  task automatic check_val(input string name);
    @(posedge clk);
    #1;
    check(name, val_out, mval);
  endtask

  // Monitor: every report pulse must match the oldest predicted press.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && key_valid_out) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", 32'(key_valid_out), 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("pulse_code", 32'(key_code_out), 32'(e.code));
          check("pulse_edge", edge_cnt, e.edge_no);
          @(negedge clk);
          check("val_after_pulse", val_out, e.val);
          check("pulse_width", 32'(key_valid_out), 32'h0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          a;
    logic [3:0]  c;
    logic [15:0] keys, prev;
    int          r, ka, kb;
    bit          clr;

    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("reset_row", 32'(row_out), 32'hE);
    check("reset_valid", 32'(key_valid_out), 32'h0);
    check("reset_code", 32'(key_code_out), 32'h0);
    check("reset_val", val_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scan: each row held SC+1 cycles, rotating.
    for (int i = 0; i < FRAME; i++) begin
      check("row_scan", 32'(row_out), 32'(~(4'b0001 << ((i / (SC + 1)) % 4)) & 4'hF));
      @(negedge clk);
    end
    model_step(16'h0, a, c);

    // Single held key.
    frames(k(1, 2), 5);
    frames(16'h0, 3);
    check_val("val_single_6");

    // Three separate presses.
    frame(16'h0, 1'b1);
    frames(k(0, 0), 3); frames(16'h0, 3);
    frames(k(0, 3), 3); frames(16'h0, 3);
    frames(k(3, 1), 3); frames(16'h0, 3);
    check_val("val_1a0");

    // Ghost / multi-key frames never report; a clean press afterwards does.
    frames(k(0, 0) | k(0, 1), 4);
    frames(k(2, 2), 2);
    frames(16'h0, 3);

    // Short and bouncing presses, then a stable one.
    frame(k(1, 0), 1'b0);
    frames(16'h0, 2);
    for (int i = 0; i < 3; i++) begin
      frame(k(2, 0), 1'b0);
      frame(16'h0, 1'b0);
    end
    frames(k(2, 0), 2);
    frames(16'h0, 3);

    // Candidate change during press wait, key change while held, release bounce.
    frame(k(0, 0), 1'b0);
    frames(k(0, 1), 2);
    frames(k(1, 1), 3);
    frames(k(1, 2), 2);
    frame(16'h0, 1'b0);
    frame(k(1, 2), 1'b0);
    frames(16'h0, 3);
    frames(k(3, 2), 2);
    frames(16'h0, 3);
    check_val("val_after_mixed");

    // Clear coinciding with the report pulse.
    frame(16'h0, 1'b1);
    frames(k(0, 0), 2); frames(16'h0, 2);
    frames(k(0, 1), 2); frames(16'h0, 2);
    check_val("val_12");
    frame(k(2, 0), 1'b0);
    frame(k(2, 0), 1'b1);
    frames(16'h0, 3);
    check_val("val_cleared");

    // Reset in the middle of a press wait.
    frames(k(0, 2), 2); frames(16'h0, 2);
    frame(k(1, 1), 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("sb_empty_pre_reset", sb_q.size(), 32'h0);
    rst_n = 1'b0;
    #1;
    check("midreset_row", 32'(row_out), 32'hE);
    check("midreset_valid", 32'(key_valid_out), 32'h0);
    check("midreset_code", 32'(key_code_out), 32'h0);
    check("midreset_val", val_out, 32'h0);
    key_mat = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_step(16'h0, a, c);
    frame(k(1, 1), 1'b0);
    frames(16'h0, 3);
    frames(k(1, 1), 2);
    frames(16'h0, 3);

    // Randomised key traffic.
    prev = '0;
    for (int f = 0; f < 80; f++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      keys = prev;
      else if (r < 7) keys = '0;
      else if (r < 9) keys = 16'(1) << $urandom_range(0, 15);
      else begin
        ka   = $urandom_range(0, 15);
        kb   = (ka + $urandom_range(1, 15)) % 16;
        keys = (16'(1) << ka) | (16'(1) << kb);
      end
      clr = ($urandom_range(0, 9) == 0);
      frame(keys, clr);
      prev = keys;
    end

    frames(16'h0, 3);
    repeat (4) @(posedge clk);
    #1;
    check("sb_empty_end", sb_q.size(), 32'h0);
    check_val("val_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
